// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding, tap record and width helper for the conv core
package conv_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN
    } state_e;

    // One entry of the read-latency delay line.
    typedef struct packed {
        logic valid;
        logic win_last;
        logic last;
    } tap_t;

    // Bits needed to count 0..n-1, never fewer than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/conv_window_addr_gen_if.sv
// rtl/conv_window_addr_gen_if.sv - controller-facing bundle of the window address generator
interface conv_window_addr_gen_if #(
    parameter int ADDR_W = 10
);
    logic              start_in;
    logic              en_in;
    logic [ADDR_W-1:0] weight_addr_out;
    logic [ADDR_W-1:0] img_addr_out;
    logic              addr_valid_out;
    logic              data_valid_out;
    logic              win_last_out;
    logic              weight_end_out;
    logic              img_end_out;

    modport master (
        output start_in, en_in,
        input  weight_addr_out, img_addr_out, addr_valid_out,
        input  data_valid_out, win_last_out, weight_end_out, img_end_out
    );

    modport slave (
        input  start_in, en_in,
        output weight_addr_out, img_addr_out, addr_valid_out,
        output data_valid_out, win_last_out, weight_end_out, img_end_out
    );
endinterface

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - LAT-stage shift register aligning tap markers with BRAM read data
module valid_delay_line
    import conv_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic flush_i,
    input  tap_t tap_i,
    output tap_t tail_o
);
    tap_t stage_q [LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else if (en_i) begin
            stage_q[0] <= tap_i;
            for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tail_o = stage_q[LAT-1];
endmodule

// File: rtl/conv_window_addr_gen.sv
// rtl/conv_window_addr_gen.sv - sweeps KxK windows over a row-major feature map, issuing weight/image addresses
module conv_window_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_window_addr_gen_if.slave bus
);
    localparam int OH = IMG_H - K + 1;
    localparam int OW = IMG_W - K + 1;
    localparam int RW = clog2(OH);
    localparam int CW = clog2(OW);
    localparam int KW = clog2(K);

    state_e        state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic [KW-1:0] kr_q, kr_d;
    logic [KW-1:0] kc_q, kc_d;

    logic kc_wrap, kr_wrap, c_wrap, r_wrap;
    logic win_end, final_tap, run, drain;
    tap_t tap_in, tap_tail;

    assign kc_wrap   = (kc_q == KW'(K - 1));
    assign kr_wrap   = (kr_q == KW'(K - 1));
    assign c_wrap    = (c_q == CW'(OW - 1));
    assign r_wrap    = (r_q == RW'(OH - 1));
    assign win_end   = kc_wrap && kr_wrap;
    assign final_tap = win_end && c_wrap && r_wrap;
    assign run       = (state_q == S_RUN);
    assign drain     = (state_q == S_DRAIN);

    // The counters wrap to zero on the final tap, so DRAIN and IDLE present address 0.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        if (bus.start_in) begin
            state_d = S_RUN;
            r_d     = '0;
            c_d     = '0;
            kr_d    = '0;
            kc_d    = '0;
        end else if (bus.en_in) begin
            case (state_q)
                S_RUN: begin
                    kc_d = kc_wrap ? '0 : kc_q + KW'(1);
                    if (kc_wrap) kr_d = kr_wrap ? '0 : kr_q + KW'(1);
                    if (win_end) c_d = c_wrap ? '0 : c_q + CW'(1);
                    if (win_end && c_wrap) r_d = r_wrap ? '0 : r_q + RW'(1);
                    if (final_tap) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (tap_tail.last) state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
        end
    end

    assign tap_in = {run, run && win_end, run && final_tap};

    valid_delay_line #(
        .LAT (LAT)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .en_i    (bus.en_in),
        .flush_i (bus.start_in),
        .tap_i   (tap_in),
        .tail_o  (tap_tail)
    );

    assign bus.weight_addr_out = ADDR_W'(kr_q) * ADDR_W'(K) + ADDR_W'(kc_q);
    assign bus.img_addr_out    = (ADDR_W'(r_q) + ADDR_W'(kr_q)) * ADDR_W'(IMG_W)
                               + ADDR_W'(c_q) + ADDR_W'(kc_q);
    assign bus.addr_valid_out  = run && bus.en_in;
    assign bus.weight_end_out  = run && final_tap && bus.en_in;
    assign bus.data_valid_out  = tap_tail.valid;
    assign bus.win_last_out    = tap_tail.win_last;
    assign bus.img_end_out     = drain && tap_tail.last && bus.en_in;
endmodule

// File: tb/tb_conv_window_addr_gen.sv
// tb/tb_conv_window_addr_gen.sv - directed and randomized checks of conv_window_addr_gen against a sweep model
`timescale 1ns/1ps
module tb_conv_window_addr_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_window_addr_gen_if #(.ADDR_W(10)) bus_a ();
    conv_window_addr_gen_if #(.ADDR_W(10)) bus_b ();

    conv_window_addr_gen #(.IMG_W(4), .IMG_H(4), .K(3), .ADDR_W(10), .LAT(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    conv_window_addr_gen #(.IMG_W(3), .IMG_H(3), .K(3), .ADDR_W(10), .LAT(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct { int w; int h; int k; int lat; int n; } cfg_t;
    typedef struct { int img; int wt; int av; int dv; int wl; int we; int ie; } obs_t;
    typedef struct { int tap; int img; int wt; } vec_t;

    cfg_t cfg [2];
    int   ref_img [2][64];
    int   ref_wt  [2][64];
    bit   m_act [2];
    int   m_e   [2];

    int cyc = 0;
    int last_cyc;
    int total;
    int bad;
    int we_cyc [2];
    int ie_cyc [2];
    int we_cnt [2];
    int ie_cnt [2];
    int wl_cnt [2];
    int cap_img [64];
    int cap_wt  [64];
    int cap_n;
    vec_t tbl [12];
    int t0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // Expected address stream: every window in raster order, every tap inside it in raster order.
    task automatic build_ref(input int d, input int w, input int h, input int k, input int lat);
        int i;
        i = 0;
        for (int r = 0; r <= h - k; r++)
            for (int c = 0; c <= w - k; c++)
                for (int kr = 0; kr < k; kr++)
                    for (int kc = 0; kc < k; kc++) begin
                        ref_img[d][i] = (r + kr) * w + (c + kc);
                        ref_wt[d][i]  = kr * k + kc;
                        i++;
                    end
        cfg[d].w = w; cfg[d].h = h; cfg[d].k = k; cfg[d].lat = lat; cfg[d].n = i;
    endtask

    // m_e counts enabled edges since the last start; tap e is presented, tap e-LAT emerges from BRAM.
    function automatic obs_t expect_obs(input int d, input bit en);
        obs_t o;
        int e, n, lat, kk;
        e = m_e[d]; n = cfg[d].n; lat = cfg[d].lat; kk = cfg[d].k * cfg[d].k;
        o.img = 0; o.wt = 0; o.av = 0; o.dv = 0; o.wl = 0; o.we = 0; o.ie = 0;
        if (m_act[d]) begin
            if (e < n) begin
                o.img = ref_img[d][e];
                o.wt  = ref_wt[d][e];
                o.av  = en ? 1 : 0;
                o.we  = (en && e == n - 1) ? 1 : 0;
            end
            if (e >= lat && e <= n - 1 + lat) begin
                o.dv = 1;
                o.wl = ((e - lat) % kk == kk - 1) ? 1 : 0;
                o.ie = (en && e == n - 1 + lat) ? 1 : 0;
            end
        end
        return o;
    endfunction

    function automatic obs_t sample(input int d);
        obs_t o;
        if (d == 0) begin
            o.img = int'(bus_a.img_addr_out);  o.wt = int'(bus_a.weight_addr_out);
            o.av  = int'(bus_a.addr_valid_out); o.dv = int'(bus_a.data_valid_out);
            o.wl  = int'(bus_a.win_last_out);  o.we = int'(bus_a.weight_end_out);
            o.ie  = int'(bus_a.img_end_out);
        end else begin
            o.img = int'(bus_b.img_addr_out);  o.wt = int'(bus_b.weight_addr_out);
            o.av  = int'(bus_b.addr_valid_out); o.dv = int'(bus_b.data_valid_out);
            o.wl  = int'(bus_b.win_last_out);  o.we = int'(bus_b.weight_end_out);
            o.ie  = int'(bus_b.img_end_out);
        end
        return o;
    endfunction

    task automatic chk_obs(input string tag, input obs_t g, input obs_t w);
        chk({tag, "_img_addr"},   g.img, w.img);
        chk({tag, "_wt_addr"},    g.wt,  w.wt);
        chk({tag, "_addr_valid"}, g.av,  w.av);
        chk({tag, "_data_valid"}, g.dv,  w.dv);
        chk({tag, "_win_last"},   g.wl,  w.wl);
        chk({tag, "_weight_end"}, g.we,  w.we);
        chk({tag, "_img_end"},    g.ie,  w.ie);
    endtask

    // One clock cycle on DUT d: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic step(input int d, input bit st, input bit en);
        obs_t g, w;
        @(negedge clk);
        bus_a.start_in = (d == 0) ? st : 1'b0;
        bus_a.en_in    = (d == 0) ? en : 1'b0;
        bus_b.start_in = (d == 1) ? st : 1'b0;
        bus_b.en_in    = (d == 1) ? en : 1'b0;
        #1;
        last_cyc = cyc;
        g = sample(d);
        w = expect_obs(d, en);
        chk_obs((d == 0) ? "a" : "b", g, w);
        if (g.we != 0) begin we_cnt[d]++; we_cyc[d] = cyc; end
        if (g.ie != 0) begin ie_cnt[d]++; ie_cyc[d] = cyc; end
        if (g.wl != 0 && g.dv != 0) wl_cnt[d]++;
        if (d == 0 && g.av != 0 && cap_n < 64) begin
            cap_img[cap_n] = g.img;
            cap_wt[cap_n]  = g.wt;
            cap_n++;
        end
        @(posedge clk);
        if (!rst) begin
            m_act[d] = 1'b0;
        end else if (st) begin
            m_act[d] = 1'b1;
            m_e[d]   = 0;
        end else if (m_act[d] && en) begin
            m_e[d]++;
            if (m_e[d] > cfg[d].n - 1 + cfg[d].lat) m_act[d] = 1'b0;
        end
    endtask

    task automatic clear_stats(input int d);
        we_cnt[d] = 0; ie_cnt[d] = 0; wl_cnt[d] = 0;
        we_cyc[d] = -1; ie_cyc[d] = -1; cap_n = 0;
    endtask

    task automatic full_sweep(input int d, input string tag);
        int t, n, lat;
        n = cfg[d].n; lat = cfg[d].lat;
        clear_stats(d);
        step(d, 1'b1, 1'b1);
        t = last_cyc;
        repeat (n + lat + 3) step(d, 1'b0, 1'b1);
        chk({tag, "_we_at"},  we_cyc[d] - t, n);
        chk({tag, "_ie_at"},  ie_cyc[d] - t, n + lat);
        chk({tag, "_we_cnt"}, we_cnt[d], 1);
        chk({tag, "_ie_cnt"}, ie_cnt[d], 1);
        chk({tag, "_wl_cnt"}, wl_cnt[d], n / (cfg[d].k * cfg[d].k));
    endtask

    initial begin
        obs_t g;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus_a.start_in = 1'b0; bus_a.en_in = 1'b0;
        bus_b.start_in = 1'b0; bus_b.en_in = 1'b0;
        build_ref(0, 4, 4, 3, 2);
        build_ref(1, 3, 3, 3, 1);
        for (int d = 0; d < 2; d++) begin m_act[d] = 1'b0; m_e[d] = 0; clear_stats(d); end

        tbl[0]  = '{0, 0, 0};  tbl[1]  = '{1, 1, 1};   tbl[2]  = '{2, 2, 2};
        tbl[3]  = '{3, 4, 3};  tbl[4]  = '{4, 5, 4};   tbl[5]  = '{5, 6, 5};
        tbl[6]  = '{6, 8, 6};  tbl[7]  = '{7, 9, 7};   tbl[8]  = '{8, 10, 8};
        tbl[9]  = '{9, 1, 0};  tbl[10] = '{18, 4, 0};  tbl[11] = '{35, 15, 8};

        // Reset state, with enable high so the gating cannot hide anything.
        step(0, 1'b1, 1'b1);
        step(1, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // Base sweep and the address table.
        full_sweep(0, "base");
        chk("base_tap_count", cap_n, 36);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("tbl_img_tap%0d", tbl[i].tap), cap_img[tbl[i].tap], tbl[i].img);
            chk($sformatf("tbl_wt_tap%0d", tbl[i].tap), cap_wt[tbl[i].tap], tbl[i].wt);
        end

        // Enable stall of three cycles at tap 10.
        clear_stats(0);
        step(0, 1'b1, 1'b1);
        t0 = last_cyc;
        repeat (10) step(0, 1'b0, 1'b1);
        repeat (3)  step(0, 1'b0, 1'b0);
        repeat (42) step(0, 1'b0, 1'b1);
        chk("stall_we_at", we_cyc[0] - t0, 39);
        chk("stall_ie_at", ie_cyc[0] - t0, 41);
        chk("stall_tap_count", cap_n, 36);

        // Restart at tap 20.
        clear_stats(0);
        step(0, 1'b1, 1'b1);
        repeat (20) step(0, 1'b0, 1'b1);
        step(0, 1'b1, 1'b1);
        t0 = last_cyc;
        repeat (42) step(0, 1'b0, 1'b1);
        chk("restart_we_cnt", we_cnt[0], 1);
        chk("restart_ie_cnt", ie_cnt[0], 1);
        chk("restart_we_at", we_cyc[0] - t0, 36);
        chk("restart_ie_at", ie_cyc[0] - t0, 38);

        // Asynchronous reset in the middle of DRAIN.
        clear_stats(0);
        step(0, 1'b1, 1'b1);
        repeat (37) step(0, 1'b0, 1'b1);
        #3;
        rst = 1'b0;
        m_act[0] = 1'b0;
        m_act[1] = 1'b0;
        #1;
        g = sample(0);
        chk("arst_img_addr",   g.img, 0);
        chk("arst_wt_addr",    g.wt,  0);
        chk("arst_addr_valid", g.av,  0);
        chk("arst_data_valid", g.dv,  0);
        chk("arst_win_last",   g.wl,  0);
        chk("arst_weight_end", g.we,  0);
        chk("arst_img_end",    g.ie,  0);
        repeat (3) step(0, 1'b0, 1'b1);
        chk("arst_no_img_end", ie_cnt[0], 0);
        @(negedge clk);
        rst = 1'b1;
        full_sweep(0, "post_rst");

        // Randomized enable and restarts against the model.
        for (int i = 0; i < 700; i++) begin
            bit st, en;
            en = ($urandom_range(0, 3) != 0);
            st = !m_act[0] ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 120) == 0);
            step(0, st, en);
        end

        // Degenerate single-window map.
        full_sweep(1, "deg");
        for (int i = 0; i < 150; i++) begin
            bit st, en;
            en = ($urandom_range(0, 2) != 0);
            st = !m_act[1] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
            step(1, st, en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_addr_gen.md
# conv_window_addr_gen

Address and sequencing stage that feeds the core controller. The controller issues init and enable to this block. The block then sweeps every K×K convolution window over an IMG_H×IMG_W feature map stored row-major in BRAM, producing the weight and image read addresses. It returns `weight_end_out` when the last address has been issued, and `img_end_out` when the last read datum emerges from the memory pipeline; these drive the controller's `weight_end_in` and `img_end_in` inputs.

## Interface
- `IMG_W`, 28: feature-map width (pixels)
- `IMG_H`, 28: feature-map height
- `K`, 3: kernel side; K ≤ IMG_W, K ≤ IMG_H
- `ADDR_W`, 10: address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H
- `LAT`, 2: BRAM read latency in cycles, ≥ 1
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start_in`  in  1  init pulse from the controller's `start_core_out`
- `en_in`  in  1  enable from the controller's `en_core_out`
- `weight_addr_out`  out  ADDR_W  weight read address, kr·K+kc
- `img_addr_out`  out  ADDR_W  image read address, (r+kr)·IMG_W+(c+kc)
- `addr_valid_out`  out  1  addresses valid this cycle
- `data_valid_out`  out  1  `addr_valid_out` delayed LAT enabled cycles; aligned with BRAM data
- `win_last_out`  out  1  aligned with data; marks the last tap (kr=kc=K−1) of a window
- `weight_end_out`  out  1  high in the cycle the final address is presented
- `img_end_out`  out  1  high in the cycle the final datum is valid

## Operation
- Output map size: OH = IMG_H−K+1, OW = IMG_W−K+1. Total taps N = OH·OW·K².
- Loop order, outermost first: r (0..OH−1), c (0..OW−1), kr (0..K−1), kc (0..K−1).
- Addresses are computed from registered counters with a single-cycle combinational multiply-add. Multiplications by K and IMG_W use constant parameters.
- States:
  - IDLE: counters held at 0; all outputs 0.
  - RUN: one tap issued per enabled cycle.
  - DRAIN: no new addresses; wait for the delay line to empty.
- Transitions:
  - IDLE→RUN on `start_in`=1; counters are cleared on the same edge.
  - RUN→DRAIN on the enabled edge after the final tap (r=OH−1, c=OW−1, kr=kc=K−1).
  - DRAIN→IDLE on the enabled edge where `img_end_out`=1.
- `start_in` in RUN or DRAIN restarts the sweep. Counters are cleared, the delay line is flushed, and the state goes to RUN. No end pulse is produced for the aborted sweep.
- `en_in`=0 freezes counters, state and the delay line. Outputs hold their values, but `addr_valid_out`, `weight_end_out` and `img_end_out` are gated to 0.
- `weight_end_out` = RUN ∧ final tap ∧ `en_in`. `img_end_out` = DRAIN ∧ last-marker bit at the delay-line tail ∧ `en_in`.
- `start_in` takes priority over all other transitions when events coincide.

## Timing
- Reset value: all outputs 0, state IDLE, delay line empty.
- `start_in` is sampled at edge T. The first address (0, 0) is presented during cycle T+1, with `addr_valid_out`=1.
- With `en_in` held high:
  - the address for tap i is presented in cycle T+1+i;
  - `weight_end_out` is high in cycle T+N;
  - `img_end_out` and the final `data_valid_out` are high in cycle T+N+LAT.
  - The state is IDLE from cycle T+N+LAT+1.
- Reset asserted mid-sweep forces IDLE immediately (asynchronously). No end pulse is produced.

## Structure
- Shared package `conv_pkg` holds the state encoding localparams (IDLE=2'b00, RUN=2'b01, DRAIN=2'b10) and a `clog2` function for counter widths. The core controller reuses the same package.
- One sub-module, `valid_delay_line`: a LAT-stage shift register carrying {valid, win_last, final}, with enable and synchronous flush.

## Test plan
- Base sweep (IMG_W=IMG_H=4, K=3, LAT=2): start at T → expect:
  - `img_addr_out` for window 0 = 0,1,2,4,5,6,8,9,10;
  - window 1 starts at 1; window 2 starts at 4;
  - last address 15;
  - `weight_end_out` only at T+36; `img_end_out` only at T+38.
- Enable stall: drop `en_in` for 3 cycles at tap 10 → addresses freeze, `addr_valid_out`=0 during the stall, and both end pulses are delayed by exactly 3 cycles.
- Restart: second `start_in` at tap 20 → the next cycle presents address 0, no end pulses for the aborted sweep, and a full 36-tap sweep follows.
- Async reset mid-DRAIN → all outputs 0 immediately, no `img_end_out`, and a subsequent start behaves as in the base sweep.
- Degenerate size (K=IMG_W=IMG_H=3, LAT=1): N=9 → `weight_end_out` at T+9, `img_end_out` at T+10, `win_last_out` only on the final datum.
- Weight addresses cycle 0..8 for every window; `win_last_out` is high every 9th `data_valid_out`.
